// File: rtl/pipeline_hazard_controller.sv
// Hazard and memory-wait controller for a five-stage pipeline: load-use/RAW stalls,
// branch flushes, data-memory freezes with timeout, and a saturating stall-cycle counter.
module pipeline_hazard_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        forwarding,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  input  logic        uses_rs_id,
  input  logic        uses_rt_id,
  input  logic        reg_write_idex,
  input  logic        mem_read_idex,
  input  logic [4:0]  writebackreg_idex,
  input  logic        reg_write_exmem,
  input  logic [4:0]  writebackreg_exmem,
  input  logic        branch_taken_ex,
  input  logic        dmem_req_mem,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        freeze,
  output logic        mem_timeout,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {StRun, StStall, StMemWait} state_e;

  state_e      state_q, state_d, ret_q, ret_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        timeout_q, timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic       hit_ex, hit_mem, mem_busy;
  logic [1:0] need;

  assign hit_ex  = (writebackreg_idex != 5'd0) &&
                   ((uses_rs_id && (rs_id == writebackreg_idex)) ||
                    (uses_rt_id && (rt_id == writebackreg_idex)));
  assign hit_mem = (writebackreg_exmem != 5'd0) &&
                   ((uses_rs_id && (rs_id == writebackreg_exmem)) ||
                    (uses_rt_id && (rt_id == writebackreg_exmem)));
  assign mem_busy = dmem_req_mem && !dmem_ready;

  // Stall depth still owed by the ID instruction; WB is write-before-read so never counts.
  always_comb begin
    need = 2'd0;
    if (forwarding) begin
      if (mem_read_idex && reg_write_idex && hit_ex) need = 2'd1;
    end else if (reg_write_idex && hit_ex) begin
      need = 2'd2;
    end else if (reg_write_exmem && hit_mem) begin
      need = 2'd1;
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    freeze      = 1'b0;
    state_d     = state_q;
    ret_d       = ret_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;

    unique case (state_q)
      StRun, StStall: begin
        if (mem_busy) begin
          freeze     = 1'b1;
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          ret_d      = state_q;
          state_d    = StMemWait;
          wcnt_d     = 8'd1;
        end else if (branch_taken_ex) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          state_d     = StRun;
          cnt_d       = 2'd0;
        end else if (state_q == StStall) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          cnt_d       = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = StRun;
        end else if (need != 2'd0) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (need == 2'd2) begin
            state_d = StStall;
            cnt_d   = need - 2'd1;
          end
        end
      end
      StMemWait: begin
        if (!dmem_ready) begin
          freeze     = 1'b1;
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          if (wcnt_q != 8'hFF) wcnt_d = wcnt_q + 8'd1;
        end else if (branch_taken_ex) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          state_d     = StRun;
          cnt_d       = 2'd0;
        end else begin
          state_d = ret_q;
        end
      end
      default: state_d = StRun;
    endcase

    // Outputs stay at their quiet values for the whole reset assertion.
    if (!rst_n) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      freeze      = 1'b0;
    end
  end

  assign timeout_d   = timeout_q || (wcnt_d == 8'hFF);
  assign stall_cnt_d = (!pc_write && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1
                                                                 : stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      ret_q       <= StRun;
      cnt_q       <= 2'd0;
      wcnt_q      <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a count-based reference model.
module tb_pipeline_hazard_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        forwarding = 1'b0;
  logic [4:0]  rs_id = '0, rt_id = '0;
  logic        uses_rs_id = 1'b0, uses_rt_id = 1'b0;
  logic        reg_write_idex = 1'b0, mem_read_idex = 1'b0;
  logic [4:0]  writebackreg_idex = '0;
  logic        reg_write_exmem = 1'b0;
  logic [4:0]  writebackreg_exmem = '0;
  logic        branch_taken_ex = 1'b0;
  logic        dmem_req_mem = 1'b0, dmem_ready = 1'b1;
  logic        pc_write, ifid_write, idex_bubble, ifid_flush, freeze, mem_timeout;
  logic [15:0] stall_count;

  int cmp_total = 0;
  int cmp_fail  = 0;

  pipeline_hazard_controller dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .forwarding         (forwarding),
    .rs_id              (rs_id),
    .rt_id              (rt_id),
    .uses_rs_id         (uses_rs_id),
    .uses_rt_id         (uses_rt_id),
    .reg_write_idex     (reg_write_idex),
    .mem_read_idex      (mem_read_idex),
    .writebackreg_idex  (writebackreg_idex),
    .reg_write_exmem    (reg_write_exmem),
    .writebackreg_exmem (writebackreg_exmem),
    .branch_taken_ex    (branch_taken_ex),
    .dmem_req_mem       (dmem_req_mem),
    .dmem_ready         (dmem_ready),
    .pc_write           (pc_write),
    .ifid_write         (ifid_write),
    .idex_bubble        (idex_bubble),
    .ifid_flush         (ifid_flush),
    .freeze             (freeze),
    .mem_timeout        (mem_timeout),
    .stall_count        (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    cmp_total++;
    if (act !== exp) begin
      cmp_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: remaining stall cycles, wait flag/length, timeout, stall total.
  int m_left = 0, m_wlen = 0, m_stalls = 0;
  bit m_wait = 0, m_to = 0;
  int nx_left, nx_wlen, nx_stalls;
  bit nx_wait, nx_to;
  bit e_pc, e_ifid, e_bub, e_fl, e_frz;

  function automatic bit hit(input logic [4:0] r);
    return (r != 5'd0) && ((uses_rs_id && rs_id == r) || (uses_rt_id && rt_id == r));
  endfunction

  always @(negedge clk) begin
    int n;
    bit frz, br, stall_now;
    n = 0;
    if (!rst_n) begin
      {e_pc, e_ifid, e_bub, e_fl, e_frz} = 5'b11000;
      nx_left = 0; nx_wlen = 0; nx_stalls = 0; nx_wait = 0; nx_to = 0;
    end else begin
      if (!m_wait && m_left == 0) begin
        if (forwarding) n = (mem_read_idex && reg_write_idex && hit(writebackreg_idex)) ? 1 : 0;
        else if (reg_write_idex && hit(writebackreg_idex)) n = 2;
        else if (reg_write_exmem && hit(writebackreg_exmem)) n = 1;
      end
      frz       = m_wait ? !dmem_ready : (dmem_req_mem && !dmem_ready);
      br        = !frz && branch_taken_ex;
      stall_now = !frz && !br && !m_wait && (m_left > 0 || n > 0);
      e_frz  = frz;
      e_fl   = br;
      e_bub  = br || stall_now;
      e_pc   = !(frz || stall_now);
      e_ifid = e_pc;
      nx_wait = frz;
      if (frz) nx_wlen = m_wait ? ((m_wlen < 255) ? m_wlen + 1 : 255) : 1;
      else nx_wlen = m_wlen;
      if (br) nx_left = 0;
      else if (frz || m_wait) nx_left = m_left;
      else if (m_left > 0) nx_left = m_left - 1;
      else nx_left = (n == 2) ? 1 : 0;
      nx_to     = m_to || (nx_wlen == 255);
      nx_stalls = (!e_pc && m_stalls < 65535) ? m_stalls + 1 : m_stalls;
    end
    chk("pc_write", 16'(pc_write), 16'(e_pc));
    chk("ifid_write", 16'(ifid_write), 16'(e_ifid));
    chk("idex_bubble", 16'(idex_bubble), 16'(e_bub));
    chk("ifid_flush", 16'(ifid_flush), 16'(e_fl));
    chk("freeze", 16'(freeze), 16'(e_frz));
    chk("mem_timeout", 16'(mem_timeout), 16'(rst_n ? m_to : 1'b0));
    chk("stall_count", stall_count, rst_n ? 16'(m_stalls) : 16'd0);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0; m_wlen <= 0; m_stalls <= 0; m_wait <= 0; m_to <= 0;
    end else begin
      m_left <= nx_left; m_wlen <= nx_wlen; m_stalls <= nx_stalls;
      m_wait <= nx_wait; m_to <= nx_to;
    end
  end

  task automatic idle();
    {uses_rs_id, uses_rt_id, reg_write_idex, mem_read_idex, reg_write_exmem} = '0;
    {rs_id, rt_id, writebackreg_idex, writebackreg_exmem} = '0;
    {branch_taken_ex, dmem_req_mem} = 2'b00;
    dmem_ready = 1'b1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_hazard();
    idle();
    forwarding = 1'b0; reg_write_idex = 1'b1; writebackreg_idex = 5'd8;
    uses_rt_id = 1'b1; rt_id = 5'd8;
  endtask

  initial begin
    // Reset with every hazard source active: outputs must stay quiet.
    alu_hazard();
    branch_taken_ex = 1'b1; dmem_req_mem = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    chk("rst_pc_write", 16'(pc_write), 16'd1);
    chk("rst_freeze", 16'(freeze), 16'd0);
    chk("rst_flush", 16'(ifid_flush), 16'd0);
    chk("rst_stall_count", stall_count, 16'd0);
    nxt(); idle(); rst_n = 1'b1;

    // Load-use with forwarding: one stall cycle.
    forwarding = 1'b1; mem_read_idex = 1'b1; reg_write_idex = 1'b1;
    writebackreg_idex = 5'd5; uses_rs_id = 1'b1; rs_id = 5'd5;
    @(negedge clk);
    chk("lu_pc_write", 16'(pc_write), 16'd0);
    chk("lu_bubble", 16'(idex_bubble), 16'd1);
    nxt(); idle();
    @(negedge clk);
    chk("lu_after_pc", 16'(pc_write), 16'd1);
    chk("lu_stall_count", stall_count, 16'd1);
    nxt();

    // ALU producer without forwarding: two stall cycles.
    alu_hazard();
    @(negedge clk); chk("alu_c1_pc", 16'(pc_write), 16'd0);
    nxt(); idle();
    @(negedge clk); chk("alu_c2_pc", 16'(pc_write), 16'd0);
    chk("alu_c2_bubble", 16'(idex_bubble), 16'd1);
    nxt();
    @(negedge clk); chk("alu_c3_pc", 16'(pc_write), 16'd1);
    chk("alu_stall_count", stall_count, 16'd3);
    nxt();

    // $zero producer never stalls, in either mode.
    for (int f = 0; f < 2; f++) begin
      idle();
      forwarding = f[0]; mem_read_idex = 1'b1; reg_write_idex = 1'b1; reg_write_exmem = 1'b1;
      uses_rs_id = 1'b1;
      @(negedge clk);
      chk("zero_pc", 16'(pc_write), 16'd1);
      chk("zero_bubble", 16'(idex_bubble), 16'd0);
      nxt();
    end

    // Branch in the first STALL cycle aborts the stall.
    alu_hazard();
    nxt(); idle(); branch_taken_ex = 1'b1;
    @(negedge clk);
    chk("br_flush", 16'(ifid_flush), 16'd1);
    chk("br_pc", 16'(pc_write), 16'd1);
    nxt(); idle();
    @(negedge clk);
    chk("br_after_pc", 16'(pc_write), 16'd1);
    chk("br_stall_count", stall_count, 16'd4);
    nxt();

    // Memory wait inside STALL: three frozen cycles, then the leftover stall cycle.
    alu_hazard();
    nxt(); idle(); dmem_req_mem = 1'b1; dmem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mw_freeze", 16'(freeze), 16'd1);
      chk("mw_bubble", 16'(idex_bubble), 16'd0);
      nxt();
    end
    dmem_ready = 1'b1;
    @(negedge clk); chk("mw_release", 16'(freeze), 16'd0);
    nxt(); idle();
    @(negedge clk);
    chk("mw_rest_pc", 16'(pc_write), 16'd0);
    chk("mw_rest_bubble", 16'(idex_bubble), 16'd1);
    nxt();
    @(negedge clk);
    chk("mw_done_pc", 16'(pc_write), 16'd1);
    chk("mw_stall_count", stall_count, 16'd9);
    nxt();

    // Reset in the middle of a STALL leaves nothing behind.
    alu_hazard();
    nxt(); idle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_stall_pc", 16'(pc_write), 16'd1);
    chk("rst_stall_count", stall_count, 16'd0);
    nxt(); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_pc", 16'(pc_write), 16'd1);
    chk("post_rst_bubble", 16'(idex_bubble), 16'd0);
    nxt();

    // 300-cycle memory wait: timeout from wait length 255, cleared by async reset.
    idle(); dmem_req_mem = 1'b1; dmem_ready = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 255) chk("to_before", 16'(mem_timeout), 16'd0);
      if (k == 256 || k == 300) chk("to_set", 16'(mem_timeout), 16'd1);
      if (k == 300) chk("to_freeze", 16'(freeze), 16'd1);
      if (k < 300) nxt();
    end
    #2 rst_n = 1'b0;
    #1 chk("to_rst_timeout", 16'(mem_timeout), 16'd0);
    chk("to_rst_count", stall_count, 16'd0);
    chk("to_rst_freeze", 16'(freeze), 16'd0);
    nxt(); idle(); rst_n = 1'b1;
    @(negedge clk);
    chk("to_post_pc", 16'(pc_write), 16'd1);
    nxt();

    // Randomized traffic; the per-cycle model check does the work here.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 19) == 0) forwarding = ~forwarding;
      rs_id = 5'($urandom_range(0, 3));
      rt_id = 5'($urandom_range(0, 3));
      uses_rs_id = 1'($urandom);
      uses_rt_id = 1'($urandom);
      reg_write_idex = 1'($urandom);
      mem_read_idex = 1'($urandom);
      writebackreg_idex = 5'($urandom_range(0, 3));
      reg_write_exmem = 1'($urandom);
      writebackreg_exmem = 5'($urandom_range(0, 3));
      branch_taken_ex = ($urandom_range(0, 9) == 0);
      dmem_req_mem = ($urandom_range(0, 3) == 0);
      dmem_ready = ($urandom_range(0, 4) < 3);
      nxt();
    end
    rst_n = 1'b1;
    idle();
    nxt();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_total, cmp_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single pipeline clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port forwarding, input, 1 bit: 1 when the forwarding unit is enabled.
REQ-004 SHALL have ports rs_id and rt_id, input, 5 bits each: source registers of the instruction in ID.
REQ-005 SHALL have ports uses_rs_id and uses_rt_id, input, 1 bit each: ID instruction reads rs / rt.
REQ-006 SHALL have ports reg_write_idex, input, 1 bit; mem_read_idex, input, 1 bit; writebackreg_idex, input, 5 bits: the producer in EX.
REQ-007 SHALL have ports reg_write_exmem, input, 1 bit; writebackreg_exmem, input, 5 bits: the producer in MEM.
REQ-008 SHALL have port branch_taken_ex, input, 1 bit: redirect resolved in EX.
REQ-009 SHALL have ports dmem_req_mem, input, 1 bit (load/store in MEM), and dmem_ready, input, 1 bit (data memory done).
REQ-010 SHALL have port pc_write, output, 1 bit, and port ifid_write, output, 1 bit.
REQ-011 SHALL have port idex_bubble, output, 1 bit: insert NOP into ID/EX.
REQ-012 SHALL have port ifid_flush, output, 1 bit.
REQ-013 SHALL have port freeze, output, 1 bit: all pipeline registers hold.
REQ-014 SHALL have port mem_timeout, output, 1 bit: sticky error flag.
REQ-015 SHALL have port stall_count, output, 16 bits: saturating count of stall cycles.

Function
REQ-016 SHALL implement states RUN, STALL and MEMWAIT, plus a 2-bit stall counter cnt and an 8-bit wait counter wcnt.
REQ-017 SHALL define a match on register R as: R≠0 and ((uses_rs_id and rs_id==R) or (uses_rt_id and rt_id==R)).
REQ-018 SHALL compute the required stall N in RUN only, as follows:
- forwarding=1: N=1 if mem_read_idex and reg_write_idex and there is a match on writebackreg_idex; otherwise N=0.
- forwarding=0: N=2 if reg_write_idex and there is a match on writebackreg_idex; otherwise N=1 if reg_write_exmem and there is a match on writebackreg_exmem; otherwise N=0.
- The register file is write-before-read, so the WB stage is never a hazard.
REQ-019 SHALL, in RUN with N≥1, combinationally drive pc_write=0, ifid_write=0 and idex_bubble=1 in that same cycle.
REQ-020 SHALL go to STALL with cnt=N-1 when N=2; when N=1 it SHALL remain in RUN.
REQ-021 SHALL, in STALL, assert pc_write=0, ifid_write=0 and idex_bubble=1; it SHALL return to RUN at the edge where cnt==1, otherwise decrement cnt.
REQ-022 SHALL ignore changes to forwarding while in STALL.
REQ-023 SHALL, when branch_taken_ex=1 and freeze=0, drive ifid_flush=1, idex_bubble=1 and pc_write=1 regardless of hazard; the next state SHALL be RUN with cnt=0, aborting any STALL.
REQ-024 SHALL, when dmem_req_mem=1 and dmem_ready=0 in RUN or STALL:
- drive freeze=1, pc_write=0 and ifid_write=0, with idex_bubble=0 and ifid_flush=0;
- enter MEMWAIT preserving cnt and the return state;
- set wcnt=1.
REQ-025 SHALL, in MEMWAIT, hold freeze=1 while dmem_ready=0 and increment wcnt, saturating at 255.
REQ-026 SHALL, in MEMWAIT when dmem_ready=1, drive freeze=0 that cycle and resume the saved state/cnt at the next edge.
REQ-027 SHALL set mem_timeout=1 when wcnt reaches 255; it SHALL stay set until reset while the wait continues normally.
REQ-028 SHALL apply output priority freeze > branch flush > data stall.
REQ-029 SHALL drive pc_write=1, ifid_write=1, and idex_bubble, ifid_flush and freeze all 0 when none of these conditions holds.
REQ-030 SHALL increment stall_count by 1 at each edge where pc_write=0, saturating at 65535.

Reset
REQ-031 SHALL, while rst_n=0, immediately force state=RUN, cnt=0, wcnt=0, mem_timeout=0 and stall_count=0.
REQ-032 SHALL drive outputs during reset as in REQ-029 regardless of the other inputs.
REQ-033 SHALL treat reset asserted mid-STALL or mid-MEMWAIT the same as reset, with no residual stall after release.

Verification
REQ-034 SHALL verify load-use with forwarding=1: mem_read_idex=1, reg_write_idex=1, writebackreg_idex=5, uses_rs_id=1, rs_id=5 -> exactly one cycle with pc_write=0 and idex_bubble=1, stall_count=1.
REQ-035 SHALL verify forwarding=0 with an ALU producer: reg_write_idex=1, writebackreg_idex=8, rt_id=8 used -> two consecutive stall cycles, then RUN.
REQ-036 SHALL verify the $zero producer: writebackreg_idex=0 matching rs_id=0 -> no stall in either forwarding mode.
REQ-037 SHALL verify a branch during STALL: branch_taken_ex=1 in STALL cycle 1 -> ifid_flush=1, pc_write=1, then RUN with no second stall cycle.
REQ-038 SHALL verify a memory wait inside STALL: dmem_ready=0 for 3 cycles -> freeze=1 for 3 cycles, then the remaining stall cycle completes.
REQ-039 SHALL verify timeout and reset: dmem_ready=0 for 300 cycles -> mem_timeout=1 from wcnt=255 onward; then rst_n=0 -> mem_timeout=0, stall_count=0, freeze=0 asynchronously.
